// File: rtl/sync_req_arbiter.sv
// -----------------------------------------------------------------------------
// sync_req_arbiter
//
// Round-robin arbiter that hands one shared resource (e.g. the AES engine) to
// one of NUM_REQ requesters whose request lines are asynchronous to clk.
// Each request is brought into the clk domain through a two-flop synchronizer.
// A grant follows a 4-phase handshake: the grantee raises req, receives grant,
// the resource pulses done, and the grantee drops req before the arbiter
// returns to IDLE.
//
// Optional feature: define SYNC_ARB_TIMEOUT_EN to enable a grant watchdog that
// revokes the grant after TIMEOUT_CYCLES cycles in GRANT without done.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  watchdog limit in clk cycles (watchdog build only)
//
// Ports
//   clk        in   system clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   async_req  in   per-requester level request, asynchronous to clk
//   done       in   1-cycle completion pulse from the shared resource
//   grant      out  registered one-hot grant (or all zero)
//   grant_id   out  index of the current/last grantee, held after grant drops
//   busy       out  high while in GRANT or RELEASE
//   aborted    out  1-cycle pulse: grantee dropped req before done
//   timeout    out  1-cycle pulse: watchdog expired (tied 0 without watchdog)
// -----------------------------------------------------------------------------
module sync_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_REQ-1:0] async_req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               aborted,
    output logic               timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] sync_p0;
    logic [NUM_REQ-1:0] sync_p1;
    logic [NUM_REQ-1:0] sreq;
    logic               sreq_cur;
    logic               pick_vld;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    ptr_next;
    logic               wdog_fire;

    // Returns {valid, index} of the first set request scanning from ptr
    // upward with wrap-around. The loop runs high-to-low so the smallest
    // offset from ptr is the last (winning) assignment.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx_v;
        int              idx;
        res = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_v = ID_W'(idx);
            if (req[idx_v]) begin
                res = {1'b1, idx_v};
            end
        end
        return res;
    endfunction

    // ---- stage p0/p1: two-flop request synchronizer ----
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= async_req;
            sync_p1 <= sync_p0;
        end
    end

    assign sreq     = sync_p1;
    assign sreq_cur = sreq[grant_id];

    // ---- arbitration decision (combinational, consumed by the FSM) ----
    always_comb begin
        {pick_vld, pick_id} = rr_pick(sreq, rr_ptr);
        ptr_next = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
    end

`ifdef SYNC_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wdog_cnt;
    logic             go_timeout;

    // Counter is zero whenever GRANT is entered because IDLE always
    // precedes GRANT and clears it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wdog_cnt <= '0;
        end else if (state == S_IDLE) begin
            wdog_cnt <= '0;
        end else if (state == S_GRANT) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_fire = (state == S_GRANT) &&
                       (wdog_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Same priority as the FSM: done first, then abort, then watchdog.
    assign go_timeout = (state == S_GRANT) && !done && sreq_cur && wdog_fire;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= go_timeout;
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // ---- FSM and registered outputs ----
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            aborted  <= 1'b0;
            rr_ptr   <= '0;
        end else begin
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant    <= NUM_REQ'(1) << pick_id;
                        grant_id <= pick_id;
                        rr_ptr   <= ptr_next;
                        state    <= S_GRANT;
                        busy     <= 1'b1;
                    end
                end
                S_GRANT: begin
                    // done outranks a simultaneous req drop or watchdog expiry
                    if (done) begin
                        grant <= '0;
                        state <= S_RELEASE;
                    end else if (!sreq_cur) begin
                        grant   <= '0;
                        aborted <= 1'b1;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (wdog_fire) begin
                        grant <= '0;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // 4-phase completion: wait for the grantee to drop req
                    if (!sreq_cur) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sync_req_arbiter
//
// Directed bench for sync_req_arbiter with NUM_REQ=4, TIMEOUT_CYCLES=16.
// Inputs change 2 time units after a rising edge; outputs are sampled at the
// same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_sync_req_arbiter;

    logic       tb_clk;
    logic       n_rst;
    logic [3:0] async_req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;
    logic       aborted;
    logic       timeout;

    int n_tests;
    int n_fail;

    sync_req_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (tb_clk),
        .n_rst     (n_rst),
        .async_req (async_req),
        .done      (done),
        .grant     (grant),
        .grant_id  (grant_id),
        .busy      (busy),
        .aborted   (aborted),
        .timeout   (timeout)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic step();
        @(posedge tb_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serve the current grantee g: done pulse, 4-phase req drop, re-raise,
    // then expect the next grant.
    task automatic serve_next(input int g, input logic [3:0] exp_grant, input logic [1:0] exp_id);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("rr_done_grant", grant, 4'b0000);
        chk("rr_done_busy", busy, 1'b1);
        async_req[g] = 1'b0;
        step();
        step();
        chk("rr_release_busy", busy, 1'b1);
        step();
        chk("rr_idle_busy", busy, 1'b0);
        async_req[g] = 1'b1;
        step();
        chk("rr_next_grant", grant, exp_grant);
        chk("rr_next_id", grant_id, exp_id);
    endtask

    initial begin
        int bad;
        n_tests   = 0;
        n_fail    = 0;
        n_rst     = 1'b1;
        async_req = 4'b0000;
        done      = 1'b0;

        // ---- 1: reset mid-cycle with all requests high ----
        step();
        async_req = 4'b1111;
        #3;
        n_rst = 1'b0;
        #1;
        chk("rst_grant_now", grant, 4'b0000);
        chk("rst_busy_now", busy, 1'b0);
        chk("rst_id_now", grant_id, 2'd0);
        chk("rst_aborted_now", aborted, 1'b0);
        chk("rst_timeout_now", timeout, 1'b0);
        step();
        step();
        chk("rst_grant_2clk", grant, 4'b0000);
        chk("rst_busy_2clk", busy, 1'b0);
        n_rst = 1'b1;
        step();
        step();
        chk("rel_grant_edge2", grant, 4'b0000);
        step();
        chk("rel_grant_edge3", grant, 4'b0001);
        chk("rel_id_edge3", grant_id, 2'd0);
        chk("rel_busy_edge3", busy, 1'b1);

        // ---- 3: round robin 0,1,2,3,0 with wrap ----
        serve_next(0, 4'b0010, 2'd1);
        serve_next(1, 4'b0100, 2'd2);
        serve_next(2, 4'b1000, 2'd3);
        serve_next(3, 4'b0001, 2'd0);

        // drain: finish grantee 0 and drop everything
        done = 1'b1;
        step();
        done = 1'b0;
        async_req = 4'b0000;
        step();
        step();
        step();
        chk("drain_busy", busy, 1'b0);
        chk("drain_grant", grant, 4'b0000);

        // done in IDLE is ignored
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("idle_done_busy", busy, 1'b0);
        chk("idle_done_grant", grant, 4'b0000);

        // ---- 2: single request on index 2 (rr_ptr=1) ----
        async_req = 4'b0100;
        step();
        step();
        chk("single_grant_edge2", grant, 4'b0000);
        step();
        chk("single_grant_edge3", grant, 4'b0100);
        chk("single_id", grant_id, 2'd2);
        chk("single_busy", busy, 1'b1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("single_done_grant", grant, 4'b0000);
        chk("single_done_busy", busy, 1'b1);
        async_req = 4'b0000;
        step();
        step();
        chk("single_rel_busy", busy, 1'b1);
        step();
        chk("single_idle_busy", busy, 1'b0);
        chk("single_id_held", grant_id, 2'd2);

        // ---- 4: abort on index 1 (rr_ptr=3, only req 1 pending) ----
        async_req = 4'b0010;
        step();
        step();
        step();
        chk("abort_grant", grant, 4'b0010);
        async_req = 4'b0000;
        step();
        step();
        chk("abort_pre_pulse", aborted, 1'b0);
        chk("abort_pre_grant", grant, 4'b0010);
        step();
        chk("abort_pulse", aborted, 1'b1);
        chk("abort_grant_drop", grant, 4'b0000);
        chk("abort_busy", busy, 1'b0);
        step();
        chk("abort_pulse_end", aborted, 1'b0);

        // ---- 5: done and req drop together (rr_ptr=2, req 3) ----
        async_req = 4'b1000;
        step();
        step();
        step();
        chk("both_grant", grant, 4'b1000);
        chk("both_id", grant_id, 2'd3);
        async_req = 4'b0000;
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("both_aborted", aborted, 1'b0);
        chk("both_grant_drop", grant, 4'b0000);
        chk("both_busy_release", busy, 1'b1);
        step();
        chk("both_idle", busy, 1'b0);
        chk("both_aborted_after", aborted, 1'b0);

        // ---- 6: watchdog (rr_ptr=0, req 0) ----
        async_req = 4'b0001;
        step();
        step();
        step();
        chk("wd_grant", grant, 4'b0001);
`ifdef SYNC_ARB_TIMEOUT_EN
        repeat (15) step();
        chk("wd_grant_15", grant, 4'b0001);
        chk("wd_timeout_15", timeout, 1'b0);
        step();
        chk("wd_timeout_pulse", timeout, 1'b1);
        chk("wd_grant_drop", grant, 4'b0000);
        chk("wd_busy_release", busy, 1'b1);
        step();
        chk("wd_timeout_end", timeout, 1'b0);
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (grant !== 4'b0001 || timeout !== 1'b0) bad++;
        end
        chk("wd_hold_100", bad, 0);
        chk("wd_busy_hold", busy, 1'b1);
`endif

        // reset while busy drops the grant immediately
        #3;
        n_rst = 1'b0;
        #1;
        chk("rst_busy_grant", grant, 4'b0000);
        chk("rst_busy_busy", busy, 1'b0);
        chk("rst_busy_id", grant_id, 2'd0);
        async_req = 4'b0000;
        step();
        n_rst = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
